// File: rtl/gnrl_pipe_dffl_if.sv
// Handshake bundle for gnrl_pipe_dffl: upstream valid/ready/data, downstream
// valid/ready/data and the occupancy count.
interface gnrl_pipe_dffl_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic [CW-1:0] cnt;

  // Environment side: produces input words and downstream ready
  modport master (
    output i_vld, i_dat, o_rdy,
    input  i_rdy, o_vld, o_dat, cnt
  );

  // Pipeline side
  modport slave (
    input  i_vld, i_dat, o_rdy,
    output i_rdy, o_vld, o_dat, cnt
  );
endinterface

// File: rtl/gnrl_pipe_dffl.sv
// Bubble-collapsing valid/ready register pipeline with load-enabled data stages.
// Optional occupancy counter is built only when GNRL_PIPE_CNT_EN is defined.
module gnrl_pipe_dffl #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   DEPTH   = 2,
  parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  gnrl_pipe_dffl_if.slave pif
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DW < 1 || DW > 256) begin : g_bad_dw
    $error("gnrl_pipe_dffl: DW out of range");
  end
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("gnrl_pipe_dffl: DEPTH out of range");
  end

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [DEPTH-1:0] can_load;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] move;
  logic [DW-1:0]    dat [DEPTH];
  logic             in_rdy;

  // Ready chain from the output back to stage 0; a stage frees up when its
  // occupant moves on, so bubbles collapse within a single cycle.
  always_comb begin
    can_load            = '0;
    can_load[DEPTH-1]   = ~vld[DEPTH-1] | pif.o_rdy;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      can_load[k] = ~vld[k] | can_load[k+1];
    end
  end

  assign in_rdy = can_load[0] & ~flush;

  // Per-stage load / move-out decisions and next valid vector
  always_comb begin
    load    = '0;
    move    = '0;
    load[0] = pif.i_vld & in_rdy;
    for (int k = 1; k < int'(DEPTH); k++) begin
      load[k] = vld[k-1] & can_load[k];
    end
    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
      move[k] = vld[k] & can_load[k+1];
    end
    move[DEPTH-1] = vld[DEPTH-1] & pif.o_rdy;
    vld_nxt       = load | (vld & ~move);
    if (flush) begin
      vld_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld <= vld_nxt;
    end
  end

  // Data only moves on a stage load; flush leaves the words in place
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        dat[k] <= RST_VAL;
      end
    end else if (!flush) begin
      if (load[0]) begin
        dat[0] <= pif.i_dat;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (load[k]) begin
          dat[k] <= dat[k-1];
        end
      end
    end
  end

  assign pif.i_rdy = in_rdy;
  assign pif.o_vld = vld[DEPTH-1];
  assign pif.o_dat = dat[DEPTH-1];

`ifdef GNRL_PIPE_CNT_EN
  logic [CW-1:0] pop;
  logic [CW-1:0] cnt_q;

  // Population count of the next valid vector, registered with it
  always_comb begin
    pop = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      pop = pop + CW'(vld_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= pop;
    end
  end

  assign pif.cnt = cnt_q;
`else
  assign pif.cnt = '0;
`endif

endmodule
